// File: rtl/lifo_master.sv
// Command-side initiator for the stack (LIFO) port: turns push/pop commands into stack write/read
// levels and returns the results. Defining LIFO_MASTER_STATS_EN adds the push/pop/error counters.
module lifo_master #(
    parameter int DATA_W    = 10,
    parameter int LIFO_SIZE = 6,
    parameter int TIMEOUT   = 15
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_pop,
    input  logic [DATA_W-1:0]                cmd_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_W-1:0]                rsp_data,
    output logic                             rsp_err,
    output logic                             stk_write,
    output logic                             stk_read,
    output logic [DATA_W-1:0]                stk_datain,
    input  logic                             stk_full,
    input  logic                             stk_val,
    input  logic [DATA_W-1:0]                stk_dataout,
    output logic [$clog2(LIFO_SIZE+1)-1:0]   occupancy
`ifdef LIFO_MASTER_STATS_EN
    ,
    output logic [15:0]                      push_cnt,
    output logic [15:0]                      pop_cnt,
    output logic [15:0]                      err_cnt
`endif
);

    localparam int OCC_W = $clog2(LIFO_SIZE + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(LIFO_SIZE);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_RESP,
        S_GAP
    } state_t;

    state_t              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                stk_write_q;
    logic                stk_read_q;
    logic [DATA_W-1:0]   stk_datain_q;
    logic [OCC_W-1:0]    occ_q;
    logic [TMR_W-1:0]    timer_q;

    logic                accept_d;
    logic                push_reject_d;
    logic                pop_reject_d;
    logic                pop_expire_d;
    logic [TMR_W-1:0]    timer_d;

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        accept_d      = 1'b0;
        push_reject_d = 1'b0;
        pop_reject_d  = 1'b0;
        timer_d       = timer_q + 1'b1;
        if (state_q == S_IDLE && cmd_valid && cmd_ready_q) begin
            accept_d = 1'b1;
        end
        push_reject_d = stk_full || (occ_q == OCC_MAX);
        pop_reject_d  = (occ_q == '0);
        pop_expire_d  = (state_q == S_POP) && !stk_val && (timer_d == TMR_MAX);
    end

    // NOTE: all state and registered outputs use <= so every update commits together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            stk_write_q  <= 1'b0;
            stk_read_q   <= 1'b0;
            stk_datain_q <= '0;
            occ_q        <= '0;
            timer_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        cmd_ready_q <= 1'b0;
                        if (!cmd_pop) begin
                            if (push_reject_d) begin
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_data_q  <= '0;
                                state_q     <= S_RESP;
                            end else begin
                                stk_datain_q <= cmd_data;
                                stk_write_q  <= 1'b1;
                                state_q      <= S_PUSH;
                            end
                        end else if (pop_reject_d) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            state_q     <= S_RESP;
                        end else begin
                            stk_read_q <= 1'b1;
                            timer_q    <= '0;
                            state_q    <= S_POP;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                S_PUSH: begin
                    stk_write_q <= 1'b0;
                    if (occ_q != OCC_MAX) begin
                        occ_q <= occ_q + 1'b1;
                    end
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    state_q     <= S_RESP;
                end

                S_POP: begin
                    if (stk_val) begin
                        stk_read_q  <= 1'b0;
                        rsp_data_q  <= stk_dataout;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (occ_q != '0) begin
                            occ_q <= occ_q - 1'b1;
                        end
                        state_q <= S_RESP;
                    end else if (pop_expire_d) begin
                        // Stack never answered: give up, leave the occupancy mirror untouched.
                        stk_read_q  <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        timer_q     <= timer_d;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_d;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                        state_q     <= S_GAP;
                    end
                end

                S_GAP: begin
                    // The stack edge-detects its inputs, so both strobes stay low here for a cycle.
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LIFO_MASTER_STATS_EN
    logic [15:0] push_cnt_q;
    logic [15:0] pop_cnt_q;
    logic [15:0] err_cnt_q;
    logic        err_entry_d;

    always_comb begin
        err_entry_d = pop_expire_d ||
                      (accept_d && ((!cmd_pop && push_reject_d) || (cmd_pop && pop_reject_d)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (state_q == S_PUSH && push_cnt_q != 16'hFFFF) begin
                push_cnt_q <= push_cnt_q + 1'b1;
            end
            if (state_q == S_POP && stk_val && pop_cnt_q != 16'hFFFF) begin
                pop_cnt_q <= pop_cnt_q + 1'b1;
            end
            if (err_entry_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign stk_write  = stk_write_q;
    assign stk_read   = stk_read_q;
    assign stk_datain = stk_datain_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_lifo_master.sv
// Scoreboard bench for lifo_master against a small behavioural stack that answers pops one cycle
// after it sees the rising edge of stk_read.
module tb_lifo_master;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_pop;
    logic [9:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [9:0] rsp_data;
    logic       rsp_err;
    logic       stk_write;
    logic       stk_read;
    logic [9:0] stk_datain;
    logic       stk_full;
    logic       stk_val;
    logic [9:0] stk_dataout;
    logic [2:0] occupancy;

    lifo_master #(.DATA_W(10), .LIFO_SIZE(6), .TIMEOUT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_pop     (cmd_pop),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .stk_write   (stk_write),
        .stk_read    (stk_read),
        .stk_datain  (stk_datain),
        .stk_full    (stk_full),
        .stk_val     (stk_val),
        .stk_dataout (stk_dataout),
        .occupancy   (occupancy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Behavioural stack.
    logic [9:0] mem [0:5];
    int         sp;
    logic       rd_q;
    bit         dead;

    assign stk_full = (sp == 6);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sp          <= 0;
            rd_q        <= 1'b0;
            stk_val     <= 1'b0;
            stk_dataout <= '0;
        end else begin
            rd_q    <= stk_read;
            stk_val <= 1'b0;
            if (stk_write && sp < 6) begin
                mem[sp] <= stk_datain;
                sp      <= sp + 1;
            end else if (stk_read && !rd_q && !dead && sp > 0) begin
                stk_val     <= 1'b1;
                stk_dataout <= mem[sp-1];
                sp          <= sp - 1;
            end
        end
    end

    int wr_cnt    = 0;
    int rd_cycles = 0;
    int both_cnt  = 0;

    always @(posedge clock) begin
        if (stk_write) wr_cnt++;
        if (stk_read) rd_cycles++;
        if (stk_write && stk_read) both_cnt++;
    end

    // Monitor: compare every response at its handshake against the scoreboard head.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'({rsp_err, rsp_data}), 32'h7FF);
            end else begin
                check("rsp_err_data", 32'({rsp_err, rsp_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input bit pop, input logic [9:0] d, input logic [9:0] ed,
                        input bit ee, input bit wait_rsp);
        int t;
        exp_q.push_back({ee, ed});
        cmd_valid = 1'b1;
        cmd_pop   = pop;
        cmd_data  = d;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        if (!cmd_ready) bound_fail("cmd_ready_wait");
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_data  = ~d;
        if (!pop && !ee) begin
            check("push_stk_write", 32'(stk_write), 1);
            @(posedge clock); #1;
            check("push_rsp_latency", 32'(rsp_valid), 1);
            check("push_write_drop", 32'(stk_write), 0);
        end
        if (wait_rsp) begin
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                @(posedge clock); #1;
                t++;
            end
            if (exp_q.size() != 0) bound_fail("rsp_wait");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        int t;
        clock     = 1'b0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_pop   = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        dead      = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_stk_write", 32'(stk_write), 0);
        check("rst_stk_read", 32'(stk_read), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_stk_datain", 32'(stk_datain), 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        // Pop on an empty stack is rejected without a read.
        rd0 = rd_cycles;
        send(1'b1, 10'h000, 10'h000, 1'b1, 1'b1);
        check("empty_pop_no_read", 32'(rd_cycles - rd0), 0);
        check("empty_pop_occ", 32'(occupancy), 0);

        // Three pushes then three pops in LIFO order.
        wr0 = wr_cnt;
        send(1'b0, 10'h155, 10'h000, 1'b0, 1'b1);
        send(1'b0, 10'h0AA, 10'h000, 1'b0, 1'b1);
        send(1'b0, 10'h3FF, 10'h000, 1'b0, 1'b1);
        check("push3_write_pulses", 32'(wr_cnt - wr0), 3);
        check("push3_occ", 32'(occupancy), 3);
        check("stack_entry0", 32'(mem[0]), 32'h155);
        check("stack_entry2", 32'(mem[2]), 32'h3FF);
        send(1'b1, 10'h000, 10'h3FF, 1'b0, 1'b1);
        send(1'b1, 10'h000, 10'h0AA, 1'b0, 1'b1);
        send(1'b1, 10'h000, 10'h155, 1'b0, 1'b1);
        check("pop3_occ", 32'(occupancy), 0);

        // Fill to six, the seventh push is rejected.
        for (int i = 1; i <= 6; i++) send(1'b0, 10'(i), 10'h000, 1'b0, 1'b1);
        check("fill_occ", 32'(occupancy), 6);
        wr0 = wr_cnt;
        send(1'b0, 10'h111, 10'h000, 1'b1, 1'b1);
        check("full_no_write", 32'(wr_cnt - wr0), 0);
        check("full_occ", 32'(occupancy), 6);

        // Stack never answers: read held exactly TIMEOUT cycles.
        dead = 1'b1;
        rd0  = rd_cycles;
        send(1'b1, 10'h000, 10'h000, 1'b1, 1'b1);
        check("timeout_read_cycles", 32'(rd_cycles - rd0), 15);
        check("timeout_occ", 32'(occupancy), 6);
        dead = 1'b0;

        // Back-pressure on the response.
        rsp_ready = 1'b0;
        send(1'b1, 10'h000, 10'h006, 1'b0, 1'b0);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        if (!rsp_valid) bound_fail("hold_rsp_wait");
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 1);
            check("hold_rsp_data", 32'(rsp_data), 32'h006);
            check("hold_cmd_ready", 32'(cmd_ready), 0);
            @(posedge clock); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        check("gap_rsp_valid", 32'(rsp_valid), 0);
        check("gap_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clock); #1;
        check("after_gap_cmd_ready", 32'(cmd_ready), 1);
        check("hold_rsp_consumed", 32'(exp_q.size()), 0);
        check("hold_occ", 32'(occupancy), 5);
        send(1'b0, 10'h02A, 10'h000, 1'b0, 1'b1);
        check("refill_occ", 32'(occupancy), 6);

        // Reset in the middle of a pop.
        dead = 1'b1;
        send(1'b1, 10'h000, 10'h000, 1'b1, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("midpop_read_high", 32'(stk_read), 1);
        #2;
        reset = 1'b1;
        #1;
        check("midpop_rst_read", 32'(stk_read), 0);
        check("midpop_rst_valid", 32'(rsp_valid), 0);
        check("midpop_rst_occ", 32'(occupancy), 0);
        exp_q.delete();
        dead = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        rd0 = rd_cycles;
        send(1'b1, 10'h000, 10'h000, 1'b1, 1'b1);
        check("post_rst_pop_no_read", 32'(rd_cycles - rd0), 0);

        check("write_read_exclusive", 32'(both_cnt), 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
